// File: rtl/fetch_pkg.sv
// Shared types and default widths for the instruction-fetch front end.
package fetch_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_DEPTH  = 4;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HOLD
    } fetch_state_t;

    typedef struct packed {
        logic [DEF_DATA_W-1:0] inst;
        logic [DEF_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous DEPTH-entry FIFO with push, pop, flush and occupancy count.
// Flush resets pointers only; storage is cleared by reset alone.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = DEF_DEPTH,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    input  logic                     flush,
    output entry_t                   head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_q, wr_d;
    logic [PTR_W-1:0]   rd_q, rd_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push) begin
                mem_d[wr_q] = push_data;
                wr_d        = wr_q + 1'b1;
            end
            if (pop) begin
                rd_d = rd_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head  = mem_q[rd_q];
    assign count = cnt_q;

endmodule

// File: rtl/inst_fetch_queue.sv
// Decoupled instruction fetch: PC/credit/FSM control feeding a fetch_fifo.
// Optional perf counters are enabled with the FETCH_PERF_EN macro.
module inst_fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned        ADDR_W   = DEF_ADDR_W,
    parameter int unsigned        DATA_W   = DEF_DATA_W,
    parameter int unsigned        DEPTH    = DEF_DEPTH,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               halt,
    input  logic               redir_valid,
    input  logic [ADDR_W-1:0]  redir_pc,
    output logic               imem_req,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [DATA_W-1:0]  imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_inst,
    output logic [ADDR_W-1:0]  out_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_flushed
`endif
);

    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W:0] DEPTH_C = DEPTH[CNT_W:0];

    typedef struct packed {
        logic [DATA_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
    } entry_t;

    fetch_state_t       state_q, state_d;
    logic [ADDR_W-1:0]  pc_q, pc_d;
    logic [ADDR_W-1:0]  req_pc_q, req_pc_d;
    logic               inflight_q, inflight_d;
    logic               kill_q, kill_d;

    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W:0]     occupancy;
    entry_t             fifo_head;
    entry_t             push_data;
    logic               pop, push, response, issue;

    assign out_valid = (fifo_count != '0);
    assign pop       = out_valid & out_ready;
    assign response  = inflight_q & ~kill_q;
    assign push      = response & ~redir_valid;

    // Credits count queued plus in-flight entries, minus the head leaving now.
    assign occupancy = {1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q}
                     - {{CNT_W{1'b0}}, pop};
    assign issue     = (state_q == RUN) & ~halt & ~redir_valid & (occupancy < DEPTH_C);

    assign imem_req  = issue;
    assign imem_addr = pc_q;
    assign push_data = '{inst: imem_rdata, pc: req_pc_q};

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT:    state_d = halt ? HOLD : RUN;
            RUN:     if (halt)  state_d = HOLD;
            HOLD:    if (!halt) state_d = RUN;
            default: state_d = BOOT;
        endcase
    end

    always_comb begin
        pc_d       = pc_q;
        req_pc_d   = req_pc_q;
        inflight_d = 1'b0;
        kill_d     = 1'b0;
        if (redir_valid) begin
            pc_d   = redir_pc;
            kill_d = inflight_q;
        end else if (issue) begin
            pc_d       = pc_q + 1'b1;
            req_pc_d   = pc_q;
            inflight_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            req_pc_q   <= '0;
            inflight_q <= 1'b0;
            kill_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            req_pc_q   <= req_pc_d;
            inflight_q <= inflight_d;
            kill_q     <= kill_d;
        end
    end

    fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .flush     (redir_valid),
        .head      (fifo_head),
        .count     (fifo_count)
    );

    assign out_inst = fifo_head.inst;
    assign out_pc   = fifo_head.pc;

`ifdef FETCH_PERF_EN
    logic [31:0] fetched_q, fetched_d;
    logic [31:0] flushed_q, flushed_d;
    logic        discard;

    // A redirect counts only if something besides the departing head is lost.
    assign discard = (fifo_count > CNT_W'(pop)) | response;

    always_comb begin
        fetched_d = fetched_q;
        flushed_d = flushed_q;
        if (pop && (fetched_q != '1)) begin
            fetched_d = fetched_q + 1'b1;
        end
        if (redir_valid && discard && (flushed_q != '1)) begin
            flushed_d = flushed_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            fetched_q <= fetched_d;
            flushed_q <= flushed_d;
        end
    end

    assign perf_fetched = fetched_q;
    assign perf_flushed = flushed_q;
`endif

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Self-checking bench for inst_fetch_queue: queue-based reference model plus directed literals.
module tb_inst_fetch_queue;

    localparam int unsigned AW     = 32;
    localparam int unsigned DW     = 32;
    localparam int unsigned DEPTH  = 4;
    localparam logic [31:0] RST_PC = 32'h10;
    localparam logic [31:0] SALT   = 32'hA5A5;

    logic        clk = 1'b0;
    logic        rst, halt, redir_valid, out_ready;
    logic [31:0] redir_pc;
    logic        imem_req, out_valid;
    logic [31:0] imem_addr, imem_rdata, out_inst, out_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_flushed;
`endif

    always #5 clk = ~clk;

    inst_fetch_queue #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .DEPTH    (DEPTH),
        .RESET_PC (RST_PC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .halt        (halt),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_inst    (out_inst),
        .out_pc      (out_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched(perf_fetched),
        .perf_flushed(perf_flushed)
`endif
    );

    // Synchronous memory: data for addr is addr^SALT; junk when no request.
    always @(posedge clk) imem_rdata <= imem_req ? (imem_addr ^ SALT) : $urandom();

    // Reference model: mode 0=boot 1=run 2=hold
    int          m_mode;
    logic [31:0] m_pc, m_fly_pc;
    bit          m_fly, m_kill;
    logic [31:0] m_q[$];
    logic [31:0] m_fetched, m_flushed;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit exp_pop();
        return (m_q.size() > 0) && out_ready;
    endfunction

    function automatic bit exp_req();
        return (m_mode == 1) && !halt && !redir_valid &&
               ((m_q.size() + int'(m_fly) - int'(exp_pop())) < int'(DEPTH));
    endfunction

    task automatic model_update();
        bit p, r;
        p = exp_pop();
        r = exp_req();
        if (!rst) begin
            m_mode = 0; m_pc = RST_PC; m_fly = 0; m_kill = 0;
            m_q.delete(); m_fetched = '0; m_flushed = '0;
            return;
        end
        if (p && m_fetched != '1) m_fetched++;
        if (redir_valid && ((m_q.size() - int'(p)) > 0 || (m_fly && !m_kill)) && m_flushed != '1)
            m_flushed++;
        case (m_mode)
            0: m_mode = halt ? 2 : 1;
            1: if (halt) m_mode = 2;
            default: if (!halt) m_mode = 1;
        endcase
        if (redir_valid) begin
            m_q.delete();
            m_pc   = redir_pc;
            m_kill = m_fly;
            m_fly  = 0;
        end else begin
            if (p) void'(m_q.pop_front());
            if (m_fly && !m_kill) m_q.push_back(m_fly_pc);
            m_kill = 0;
            m_fly  = r;
            if (r) begin
                m_fly_pc = m_pc;
                m_pc     = m_pc + 1;
            end
        end
    endtask

    task automatic compare();
        chk("imem_req", 32'(imem_req), 32'(exp_req()));
        chk("imem_addr", imem_addr, m_pc);
        chk("out_valid", 32'(out_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk("out_pc", out_pc, m_q[0]);
            chk("out_inst", out_inst, m_q[0] ^ SALT);
        end
`ifdef FETCH_PERF_EN
        chk("perf_fetched", perf_fetched, m_fetched);
        chk("perf_flushed", perf_flushed, m_flushed);
`endif
    endtask

    task automatic cycle(input bit r, input bit h, input bit rv, input logic [31:0] rp, input bit rdy);
        @(posedge clk);
        model_update();
        @(negedge clk);
        rst = r; halt = h; redir_valid = rv; redir_pc = rp; out_ready = rdy;
        #1;
        compare();
    endtask

    initial begin
        int          n_req;
        logic [31:0] saved_pc;
        rst = 0; halt = 0; redir_valid = 0; redir_pc = '0; out_ready = 1;

        repeat (3) cycle(0, 0, 0, '0, 1);

        // Cycle 0 (BOOT): reset values
        cycle(1, 0, 0, '0, 1);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h10);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_inst", out_inst, 32'd0);
        chk("rst_pc", out_pc, 32'd0);
        cycle(1, 0, 0, '0, 1);
        chk("c1_req", 32'(imem_req), 32'd1);
        chk("c1_addr", imem_addr, 32'h10);
        cycle(1, 0, 0, '0, 1);
        cycle(1, 0, 0, '0, 1);
        chk("c3_valid", 32'(out_valid), 32'd1);
        chk("c3_pc", out_pc, 32'h10);
        chk("c3_inst", out_inst, 32'h0000A5B5);
        cycle(1, 0, 0, '0, 1);
        chk("c4_pc", out_pc, 32'h11);
        chk("c4_inst", out_inst, 32'h0000A5B4);
        cycle(1, 0, 0, '0, 1);
        chk("c5_pc", out_pc, 32'h12);
        chk("c5_inst", out_inst, 32'h0000A5B7);

        // Stall, then redirect with queued entries and a response in flight
        cycle(1, 0, 0, '0, 0);
        cycle(1, 0, 1, 32'h200, 0);
        n_req = 0;
        for (int i = 0; i < 10; i++) begin
            cycle(1, 0, 0, '0, 0);
            if (i == 0) begin
                chk("redir_valid_t1", 32'(out_valid), 32'd0);
                chk("redir_addr_t1", imem_addr, 32'h200);
            end
            if (imem_req) n_req++;
        end
        chk("stall_req_count", 32'(n_req), 32'd4);
        chk("stall_head_pc", out_pc, 32'h200);
        for (int i = 0; i < 4; i++) begin
            cycle(1, 0, 0, '0, 1);
            chk("drain_pc", out_pc, 32'h200 + 32'(i));
            if (i == 0) begin
                chk("resume_req", 32'(imem_req), 32'd1);
                chk("resume_addr", imem_addr, 32'h204);
            end
        end

        // Halt: no issue in the same cycle, queue drains, sequential resume
        cycle(1, 1, 0, '0, 1);
        chk("halt_req", 32'(imem_req), 32'd0);
        saved_pc = m_pc;
        repeat (7) cycle(1, 1, 0, '0, 1);
        chk("halt_drained", 32'(out_valid), 32'd0);
        cycle(1, 0, 0, '0, 1);
        cycle(1, 0, 0, '0, 1);
        chk("unhalt_req", 32'(imem_req), 32'd1);
        chk("unhalt_addr", imem_addr, saved_pc);
        repeat (4) cycle(1, 0, 0, '0, 1);

        // PC wrap
        cycle(1, 0, 1, 32'hFFFF_FFFF, 1);
        cycle(1, 0, 0, '0, 1);
        chk("wrap_addr0", imem_addr, 32'hFFFF_FFFF);
        chk("wrap_req0", 32'(imem_req), 32'd1);
        cycle(1, 0, 0, '0, 1);
        chk("wrap_addr1", imem_addr, 32'h0000_0000);
        repeat (4) cycle(1, 0, 0, '0, 1);

        // Reset mid-operation with a filling queue and a fetch in flight
        repeat (3) cycle(1, 0, 0, '0, 0);
        cycle(0, 0, 0, '0, 0);
        cycle(1, 0, 0, '0, 0);
        chk("midrst_valid", 32'(out_valid), 32'd0);
        chk("midrst_req", 32'(imem_req), 32'd0);
`ifdef FETCH_PERF_EN
        chk("midrst_fetched", perf_fetched, 32'd0);
        chk("midrst_flushed", perf_flushed, 32'd0);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            bit          r, h, rv, rdy;
            logic [31:0] rp;
            r   = ($urandom_range(0, 199) != 0);
            h   = ($urandom_range(0, 99) < 10);
            rv  = ($urandom_range(0, 99) < 5);
            rdy = ($urandom_range(0, 99) < 70);
            rp  = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFE + 32'($urandom_range(0, 1)))
                                               : 32'($urandom_range(0, 16'hFFFF));
            cycle(r, h, rv, rp, rdy);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
